des_key_sched_seq: RTL and testbench
====================================

Name: des_key_sched_seq

Overview:
- Sequential, parametrised DES key-schedule generator.
- Loads a 56-bit post-PC-1 key (C||D halves) and emits one rotated round key per accepted beat, rounds 1..ROUNDS, over a valid/ready stream.
- Supports encrypt order (left rotates) and decrypt order (right rotates, reverse round order).
- Sits between the PC-1 stage and the PC-2/round-function pipeline; replaces the all-rounds-at-once combinational shifter with one registered key stream.

Parameters:
- HALF_W, 28: width of each half C and D. Key width is 2*HALF_W. Must be ≥2.
- ROUNDS, 16: number of round keys per operation.
- SHIFT_SCHED, 16'h7EFC: ROUNDS bits. Bit i-1 = 1 means encrypt round i rotates by 2; 0 means it rotates by 1. Rotation total must be ≡0 mod HALF_W.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin an operation. Sampled only in IDLE.
- decrypt, in, 1: mode select, sampled with start. 0 = encrypt order, 1 = decrypt order.
- key_in, in, 2*HALF_W: C = key_in[2*HALF_W-1:HALF_W], D = key_in[HALF_W-1:0]. Sampled with start.
- abort, in, 1: return to IDLE immediately.
- busy, out, 1: high in EMIT.
- subkey_valid, out, 1: round key available.
- subkey_ready, in, 1: consumer accepts the key.
- subkey_out, out, 2*HALF_W: {C,D} for the current round.
- round_idx, out, $clog2(ROUNDS+1): current round number, 1..ROUNDS.
- last, out, 1: subkey_valid high and round_idx == ROUNDS.
- done, out, 1: one-cycle pulse after the final key is accepted.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE. busy, subkey_valid, last and done = 0. subkey_out = 0. round_idx = 0. Latched mode = 0. Reset overrides all other inputs, including in mid-operation.
- Rotations:
  - Left-1 of a half H is {H[HALF_W-2:0],H[HALF_W-1]}.
  - Right rotates are the mirror of left rotates.
  - Each half rotates independently; C and D never exchange bits.
- Encrypt:
  - Key for round r = CD0 rotated left by the cumulative sum of the amounts for rounds 1..r.
  - Each step rotates the registered key left by amt(r), where amt(r) = 2 if SHIFT_SCHED[r-1] = 1, else 1.
- Decrypt:
  - Round 1 outputs CD0 unchanged (equals encrypt key ROUNDS).
  - Step to round r (r≥2) rotates right by amt(ROUNDS-r+2).
  - Decrypt round r therefore equals encrypt round ROUNDS-r+1.
- IDLE:
  - start=1 latches decrypt and loads subkey_out with the round-1 key: rotate-left by amt(1) for encrypt, key_in for decrypt.
  - Same edge sets round_idx=1, subkey_valid=1, busy=1. Next state EMIT.
  - Latency is 1 cycle from the start edge to valid.
- EMIT:
  - subkey_valid=1 and ready=1 with round_idx<ROUNDS: next edge loads the next key and increments round_idx. Throughput is one key per cycle, valid stays high.
  - subkey_valid=1 and ready=0: subkey_out, round_idx and last hold stable.
  - ready=1 with round_idx==ROUNDS: next edge goes to IDLE; subkey_valid, busy and last drop to 0, done=1 for exactly that cycle. round_idx and subkey_out hold their last values.
- start while busy is ignored; changes to key_in and decrypt in EMIT have no effect.
- A start arriving in the done cycle (IDLE) is accepted normally.
- abort=1 (rst=0) in any state: next edge goes to IDLE, valid, busy and last drop to 0, done not asserted. abort takes precedence over start and ready on the same edge.
- All outputs are registered. last is decoded from registered state, with no combinational path from ready to valid or data.

Test Plan:
- Encrypt, key_in=56'h0000001_8000000, ready held 1, start 1 cycle → valid at +1 cycle.
  - Round1 = 56'h0000002_0000001, round2 = 56'h0000004_0000002, round3 = 56'h0000010_0000008.
  - Round16 = 56'h0000001_8000000 with last=1. done pulses 1 cycle after; 16 consecutive valid cycles.
- Decrypt, same key:
  - Round1 = 56'h0000001_8000000, round2 = 56'h8000000_4000000.
  - Every round r equals encrypt round 17-r. Round16 = 56'h0000002_0000001.
- Backpressure: ready=0 for 3 cycles at round_idx=5.
  - subkey_out and round_idx are stable all 3 cycles; no round is skipped or duplicated.
  - Total accepted keys = 16.
- start=1 with a different key during round 8 → ignored, sequence unchanged. start in the done cycle → new operation, valid on the next cycle.
- rst=1 at round 10 → the next cycle has all outputs 0 and the state is IDLE. abort at round 4 → valid=0 next cycle, no done pulse, and a fresh start works.
- Parameter sweep: HALF_W=8, ROUNDS=4, SHIFT_SCHED=4'b1111 (total 8). Round4 encrypt = key_in; decrypt round1 = key_in, round2 = each half rotated right by 2.

Source files
------------

// File: rtl/des_key_sched_seq.sv
// des_key_sched_seq: streams the DES round keys, one per accepted beat, from a post-PC-1 key.
// Encrypt order rotates left; decrypt order starts at CD0 and rotates right.
module des_key_sched_seq #(
    parameter int                HALF_W      = 28,
    parameter int                ROUNDS      = 16,
    parameter logic [ROUNDS-1:0] SHIFT_SCHED = 16'h7EFC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          decrypt,
    input  logic [2*HALF_W-1:0]           key_in,
    input  logic                          abort,
    output logic                          busy,
    output logic                          subkey_valid,
    input  logic                          subkey_ready,
    output logic [2*HALF_W-1:0]           subkey_out,
    output logic [$clog2(ROUNDS+1)-1:0]   round_idx,
    output logic                          last,
    output logic                          done
);
    localparam int                KW    = 2*HALF_W;
    localparam int                RW    = $clog2(ROUNDS+1);
    localparam logic [RW-1:0]     R_MAX = RW'(ROUNDS);
    localparam logic [ROUNDS-1:0] ONE   = 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   key_q, key_d;
    logic [RW-1:0]   round_q, round_d;
    logic            mode_q, mode_d;
    logic            done_q, done_d;
    logic [RW-1:0]   amt_idx;
    logic            step_two;

    function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] h, input logic right, input logic two);
        int n;
        n = two ? 2 : 1;
        return right ? ((h >> n) | (h << (HALF_W-n))) : ((h << n) | (h >> (HALF_W-n)));
    endfunction

    function automatic logic [KW-1:0] rot_key(input logic [KW-1:0] k, input logic right, input logic two);
        return {rot_half(k[KW-1:HALF_W], right, two), rot_half(k[HALF_W-1:0], right, two)};
    endfunction

    // Stepping from round r: encrypt uses amt(r+1), decrypt uses amt(ROUNDS-r+1).
    assign amt_idx  = mode_q ? (R_MAX - round_q) : round_q;
    assign step_two = |(SHIFT_SCHED & (ONE << amt_idx));

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else if (state_q == IDLE && start) begin
            state_d = EMIT;
            mode_d  = decrypt;
            key_d   = decrypt ? key_in : rot_key(key_in, 1'b0, SHIFT_SCHED[0]);
            round_d = RW'(1);
        end else if (state_q == EMIT && subkey_ready) begin
            if (round_q == R_MAX) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                key_d   = rot_key(key_q, mode_q, step_two);
                round_d = round_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign subkey_valid = (state_q == EMIT);
    assign busy         = (state_q == EMIT);
    assign last         = (state_q == EMIT) && (round_q == R_MAX);
    assign subkey_out   = key_q;
    assign round_idx    = round_q;
    assign done         = done_q;
endmodule

// File: tb/tb_des_key_sched_seq.sv
// tb_des_key_sched_seq: directed checks of the default 28/16 schedule and an 8/4 variant.
module tb_des_key_sched_seq;
    localparam logic [15:0] SCHED = 16'h7EFC;
    localparam logic [55:0] K1 = 56'h0000001_8000000;
    localparam logic [55:0] K2 = 56'h9ABCDEF_1234567;
    localparam logic [55:0] K3 = 56'hFEDCBA9_8765432;

    logic        clk = 1'b0;
    logic        rst, start, decrypt, abort, subkey_ready;
    logic [55:0] key_in, subkey_out;
    logic        busy, subkey_valid, last, done;
    logic [4:0]  round_idx;

    logic        p_start, p_decrypt, p_abort, p_ready;
    logic [15:0] p_key_in, p_subkey_out;
    logic        p_busy, p_valid, p_last, p_done;
    logic [2:0]  p_round_idx;

    int n_cmp = 0;
    int n_err = 0;

    des_key_sched_seq dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in), .abort(abort),
        .busy(busy), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
        .subkey_out(subkey_out), .round_idx(round_idx), .last(last), .done(done)
    );

    des_key_sched_seq #(.HALF_W(8), .ROUNDS(4), .SHIFT_SCHED(4'b1111)) dut_p (
        .clk(clk), .rst(rst), .start(p_start), .decrypt(p_decrypt), .key_in(p_key_in), .abort(p_abort),
        .busy(p_busy), .subkey_valid(p_valid), .subkey_ready(p_ready),
        .subkey_out(p_subkey_out), .round_idx(p_round_idx), .last(p_last), .done(p_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: rotate each half left one bit at a time by the cumulative amount.
    function automatic logic [55:0] enc_model(input logic [55:0] k, input int r);
        logic [27:0] c, d;
        int s;
        c = k[55:28];
        d = k[27:0];
        s = 0;
        for (int i = 0; i < r; i++) s += SCHED[i] ? 2 : 1;
        repeat (s) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    function automatic logic [55:0] dec_model(input logic [55:0] k, input int r);
        return enc_model(k, 17 - r);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({busy, subkey_valid, last, done, round_idx, subkey_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got b%b v%b l%b d%b r%0d k%h, expected all 0", busy, subkey_valid, last, done, round_idx, subkey_out);
        end
        n_cmp++;
        if ({p_busy, p_valid, p_last, p_done, p_round_idx, p_subkey_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_p: got v%b r%0d k%h, expected all 0", p_valid, p_round_idx, p_subkey_out);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (subkey_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: valid %b expected 0", subkey_valid);
        end
    endtask

    task automatic test_encrypt();
        logic [55:0] c;
        subkey_ready = 1'b1;
        key_in = K1;
        decrypt = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        key_in = '0;
        for (int r = 1; r <= 16; r++) begin
            n_cmp++;
            if ({subkey_valid, busy, last, round_idx} !== {1'b1, 1'b1, r == 16, 5'(r)}) begin
                n_err++;
                $display("FAIL enc_ctrl r%0d: got v%b b%b l%b idx%0d", r, subkey_valid, busy, last, round_idx);
            end
            n_cmp++;
            if (subkey_out !== enc_model(K1, r)) begin
                n_err++;
                $display("FAIL enc_key r%0d: got %h expected %h", r, subkey_out, enc_model(K1, r));
            end
            c = r == 1 ? 56'h0000002_0000001 : r == 2 ? 56'h0000004_0000002 : r == 3 ? 56'h0000010_0000008 : K1;
            if (r <= 3 || r == 16) begin
                n_cmp++;
                if (subkey_out !== c) begin
                    n_err++;
                    $display("FAIL enc_const r%0d: got %h expected %h", r, subkey_out, c);
                end
            end
            tick();
        end
        n_cmp++;
        if ({done, subkey_valid, busy, last, round_idx, subkey_out} !== {4'b1000, 5'd16, K1}) begin
            n_err++;
            $display("FAIL enc_done: got d%b v%b b%b l%b idx%0d k%h", done, subkey_valid, busy, last, round_idx, subkey_out);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL enc_done_pulse: done %b expected 0", done);
        end
    endtask

    task automatic test_decrypt();
        logic [55:0] c;
        key_in = K1;
        decrypt = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        decrypt = 1'b0;
        for (int r = 1; r <= 16; r++) begin
            n_cmp++;
            if ({subkey_valid, last, round_idx} !== {1'b1, r == 16, 5'(r)}) begin
                n_err++;
                $display("FAIL dec_ctrl r%0d: got v%b l%b idx%0d", r, subkey_valid, last, round_idx);
            end
            n_cmp++;
            if (subkey_out !== dec_model(K1, r)) begin
                n_err++;
                $display("FAIL dec_key r%0d: got %h expected %h", r, subkey_out, dec_model(K1, r));
            end
            c = r == 1 ? K1 : r == 2 ? 56'h8000000_4000000 : 56'h0000002_0000001;
            if (r <= 2 || r == 16) begin
                n_cmp++;
                if (subkey_out !== c) begin
                    n_err++;
                    $display("FAIL dec_const r%0d: got %h expected %h", r, subkey_out, c);
                end
            end
            tick();
        end
        n_cmp++;
        if ({done, subkey_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL dec_done: got d%b v%b expected d1 v0", done, subkey_valid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        key_in = K2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 1; r <= 16; r++) begin
            n_cmp++;
            if ({round_idx, subkey_out} !== {5'(r), enc_model(K2, r)}) begin
                n_err++;
                $display("FAIL bp_key r%0d: got idx%0d %h expected %h", r, round_idx, subkey_out, enc_model(K2, r));
            end
            if (r == 5) begin
                subkey_ready = 1'b0;
                repeat (3) begin
                    acc += (subkey_valid && subkey_ready) ? 1 : 0;
                    tick();
                    n_cmp++;
                    if ({subkey_valid, last, round_idx, subkey_out} !== {2'b10, 5'd5, enc_model(K2, 5)}) begin
                        n_err++;
                        $display("FAIL bp_hold: got v%b idx%0d %h expected idx5 %h", subkey_valid, round_idx, subkey_out, enc_model(K2, 5));
                    end
                end
                subkey_ready = 1'b1;
            end
            acc += (subkey_valid && subkey_ready) ? 1 : 0;
            tick();
        end
        n_cmp++;
        if (acc !== 16 || done !== 1'b1) begin
            n_err++;
            $display("FAIL bp_count: accepted %0d done %b expected 16 and 1", acc, done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        key_in = K3;
        decrypt = 1'b1;
        start = 1'b1;
        tick();
        for (int r = 1; r <= 16; r++) begin
            start = (r == 8);
            key_in = (r == 8) ? K1 : K3;
            decrypt = (r != 8);
            n_cmp++;
            if ({round_idx, subkey_out} !== {5'(r), dec_model(K3, r)}) begin
                n_err++;
                $display("FAIL busy_start r%0d: got idx%0d %h expected %h", r, round_idx, subkey_out, dec_model(K3, r));
            end
            tick();
        end
        n_cmp++;
        if ({done, subkey_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_done: got d%b v%b expected d1 v0", done, subkey_valid);
        end
        key_in = K1;
        decrypt = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({subkey_valid, done, round_idx, subkey_out} !== {2'b10, 5'd1, enc_model(K1, 1)}) begin
            n_err++;
            $display("FAIL b2b_restart: got v%b d%b idx%0d %h expected idx1 %h", subkey_valid, done, round_idx, subkey_out, enc_model(K1, 1));
        end
    endtask

    task automatic test_reset_mid();
        repeat (9) tick();
        n_cmp++;
        if (round_idx !== 5'd10) begin
            n_err++;
            $display("FAIL rst_mid_pre: idx %0d expected 10", round_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, subkey_valid, last, done, round_idx, subkey_out} !== '0) begin
            n_err++;
            $display("FAIL rst_mid: got v%b b%b idx%0d %h expected all 0", subkey_valid, busy, round_idx, subkey_out);
        end
        tick();
        n_cmp++;
        if (subkey_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_idle: valid %b expected 0", subkey_valid);
        end
    endtask

    task automatic test_abort();
        key_in = K2;
        decrypt = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (round_idx !== 5'd4) begin
            n_err++;
            $display("FAIL abort_pre: idx %0d expected 4", round_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({subkey_valid, busy, last, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL abort: got v%b b%b l%b d%b expected 0000", subkey_valid, busy, last, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: done %b expected 0", done);
        end
        abort = 1'b1;
        decrypt = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (subkey_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_over_start: valid %b expected 0", subkey_valid);
        end
        tick();
        start = 1'b0;
        n_cmp++;
        if ({subkey_valid, round_idx, subkey_out} !== {1'b1, 5'd1, K2}) begin
            n_err++;
            $display("FAIL abort_restart: got v%b idx%0d %h expected idx1 %h", subkey_valid, round_idx, subkey_out, K2);
        end
        tick();
        n_cmp++;
        if (subkey_out !== dec_model(K2, 2)) begin
            n_err++;
            $display("FAIL abort_restart_r2: got %h expected %h", subkey_out, dec_model(K2, 2));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_param();
        logic [15:0] pe [1:4];
        logic [15:0] pd [1:4];
        pe = '{16'h96F0, 16'h5AC3, 16'h690F, 16'hA53C};
        pd = '{16'hA53C, 16'h690F, 16'h5AC3, 16'h96F0};
        for (int m = 0; m < 2; m++) begin
            p_key_in = 16'hA53C;
            p_decrypt = (m == 1);
            p_start = 1'b1;
            tick();
            p_start = 1'b0;
            for (int r = 1; r <= 4; r++) begin
                n_cmp++;
                if ({p_valid, p_last, p_round_idx, p_subkey_out} !== {1'b1, r == 4, 3'(r), (m == 1) ? pd[r] : pe[r]}) begin
                    n_err++;
                    $display("FAIL param m%0d r%0d: got v%b l%b idx%0d %h expected %h", m, r, p_valid, p_last, p_round_idx, p_subkey_out, (m == 1) ? pd[r] : pe[r]);
                end
                tick();
            end
            n_cmp++;
            if ({p_done, p_valid} !== 2'b10) begin
                n_err++;
                $display("FAIL param_done m%0d: got d%b v%b expected d1 v0", m, p_done, p_valid);
            end
            tick();
        end
    endtask

    initial begin
        {rst, start, decrypt, abort, subkey_ready, key_in} = '0;
        {p_start, p_decrypt, p_abort, p_ready, p_key_in} = '0;
        p_ready = 1'b1;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_abort();
        test_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
